// File: rtl/uart_rx_os16.sv
// UART 8N1 receiver on a 16x-oversampled clock with a one-entry valid/ready output buffer.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_os16 #(
  parameter int unsigned OSR         = 16,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] d_rx,
  output logic                 vld_rx,
  input  logic                 rdy_rx,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CntW = $clog2(OSR);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OSR / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OSR - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  logic [SYNC_STAGES-1:0] sync_q, fill_q;
  logic                   rxd_s;
  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [IdxW-1:0]        idx_q;
  logic [DATA_BITS-1:0]   shift_q, d_rx_q;
  logic                   armed_q, done_q, frame_err_q, vld_q, overrun_q;
  logic                   par_ok;

  // fill_q tracks how far real line data has propagated through the synchroniser since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
  logic par_ok_q;
  assign par_ok = par_ok_q;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q    <= 1'b1;
`endif
    end else begin
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // Never start on a line that was already low when reset was released.
          if (!armed_q) begin
            if (fill_q[SYNC_STAGES-1] && rxd_s) armed_q <= 1'b1;
          end else if (!rxd_s) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rxd_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == CntLast) begin
            cnt_q    <= '0;
            par_ok_q <= ~^{shift_q, rxd_s};
            state_q  <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (!rxd_s) begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end else begin
              frame_err_q <= ~par_ok;
              done_q      <= par_ok;
              state_q     <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBreak: begin
          if (rxd_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A byte completing in the same cycle as an accept replaces the old one without overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_rx_q    <= '0;
      vld_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (vld_q && rdy_rx) vld_q <= 1'b0;
      if (done_q) begin
        if (vld_q && !rdy_rx) begin
          overrun_q <= 1'b1;
        end else begin
          d_rx_q <= shift_q;
          vld_q  <= 1'b1;
        end
      end
    end
  end

  assign d_rx      = d_rx_q;
  assign vld_rx    = vld_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: serial frames in, accepted bytes checked against a queue.
module tb_uart_rx_os16;

  localparam int OSR = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] d_rx;
  logic       vld_rx;
  logic       rdy_rx;
  logic       frame_err;
  logic       overrun;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;

  logic [7:0] exp_q[$];

  uart_rx_os16 #(.OSR(OSR), .DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .d_rx     (d_rx),
    .vld_rx   (vld_rx),
    .rdy_rx   (rdy_rx),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge view matches what the next posedge sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld_rx && rdy_rx) begin
        logic [7:0] e;
        n_acc++;
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_byte: observed %02h required none", d_rx);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_assert++;
          assert (d_rx === e) else begin
            n_fail++;
            $error("FAIL rx_data: observed %02h required %02h", d_rx, e);
          end
        end
      end
      if (frame_err === 1'b1) n_ferr++;
      if (overrun === 1'b1) n_ovr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    tick(OSR);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`else
    if (par_flip) send_bit(1'b1);
`endif
    send_bit(stop_v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_rx"}, {24'd0, d_rx}, 32'h0);
    check({tag, "_vld_rx"}, {31'd0, vld_rx}, 32'h0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'h0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'h0);
  endtask

  initial begin
    int         f0;
    int         o0;
    int         a0;
    logic [7:0] partial;

    rst    = 1'b1;
    rxd    = 1'b1;
    rdy_rx = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(10);

    // 1: single frame
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    tick(2 * OSR);
    check("t1_drained", exp_q.size(), 0);
    check("t1_acc", n_acc, 1);
    check("t1_ferr", n_ferr, 0);
    check("t1_ovr", n_ovr, 0);

    // 2: back-to-back frames
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(2 * OSR);
    check("t2_drained", exp_q.size(), 0);
    check("t2_acc", n_acc, 3);

    // 3: short glitch is ignored
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(2 * OSR);
    check("t3_glitch_acc", n_acc, 3);
    check("t3_glitch_vld", {31'd0, vld_rx}, 32'h0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    tick(2 * OSR);
    check("t3_drained", exp_q.size(), 0);

    // 4: bad stop bit then break
    f0 = n_ferr;
    a0 = n_acc;
    send_frame(8'h81, 1'b0, 1'b0);
    tick(40);
    rxd = 1'b1;
    tick(2 * OSR);
    check("t4_ferr_once", n_ferr - f0, 1);
    check("t4_no_byte", n_acc - a0, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    tick(2 * OSR);
    check("t4_drained", exp_q.size(), 0);
    check("t4_ferr_total", n_ferr - f0, 1);

    // 5: overrun with consumer stalled
    rdy_rx = 1'b0;
    o0 = n_ovr;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2 * OSR);
    check("t5_vld_held", {31'd0, vld_rx}, 32'h1);
    check("t5_d_rx_kept", {24'd0, d_rx}, 32'h11);
    check("t5_ovr_once", n_ovr - o0, 1);
    rdy_rx = 1'b1;
    tick(2);
    check("t5_vld_drop", {31'd0, vld_rx}, 32'h0);
    check("t5_drained", exp_q.size(), 0);

    // 6: reset mid-DATA
    partial = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(partial[i]);
    tick(3);
    rst = 1'b1;
    rxd = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_reset_outputs("t6_after_rst");
    tick(10);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(2 * OSR);
    check("t6_drained", exp_q.size(), 0);
`ifdef UART_RX_PARITY_EN
    f0 = n_ferr;
    a0 = n_acc;
    send_frame(8'hC3, 1'b1, 1'b1);
    tick(2 * OSR);
    check("t6_par_ferr", n_ferr - f0, 1);
    check("t6_par_no_byte", n_acc - a0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
